// File: rtl/ink_register_writer.sv
// ink_register_writer: palette ink writer for a CPU-facing gate array.
// Detects WR_n falling edges, decodes the data byte into pen selects or
// colour writes, and holds one colour write pending until the next
// pixel-boundary strobe (PIX_LOAD) so palette changes land on pixel edges.
//
// Optional feature macro: INK_WR_SYNC_EN
//   defined   -> WR_n passes a 2-flop synchroniser before edge detection
//                (capture happens 2 CLK_n cycles later; hold D accordingly)
//   undefined -> WR_n is sampled directly by the edge-history flop
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no colour write outstanding
// PEND  | one captured colour write waiting for a PIX_LOAD edge to commit

module ink_register_writer (
  input  logic        CLK_n,
  input  logic        RESET,
  input  logic        WR_n,
  input  logic [7:0]  D,
  input  logic        PIX_LOAD,
  output logic [15:0] INKR0,
  output logic [15:0] INKR1,
  output logic [15:0] INKR2,
  output logic [15:0] INKR3,
  output logic [15:0] INKR4,
  output logic [4:0]  BORDER,
  output logic [4:0]  PEN,
  output logic        PENDING
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Edge history for WR_n (reset to 1 so reset release never looks like an edge)
  logic wr_prev_q, wr_prev_d;
  logic wr_sampled;

  // Selected pen and border colour
  logic [4:0] pen_q, pen_d;
  logic [4:0] border_q, border_d;

  // One-entry pending buffer: target pen is frozen at capture time
  logic [4:0] tgt_q, tgt_d;
  logic [4:0] col_q, col_d;

  // Ink bit-planes: ink_q[b][p] is bit b of pen p's hardware colour
  logic [4:0][15:0] ink_q, ink_d;

  logic wr_fall;
  logic is_pen_sel;
  logic is_col_wr;
  logic commit;

  // D[5] carries no meaning for either command
  logic unused_d5;
  assign unused_d5 = D[5];

`ifdef INK_WR_SYNC_EN
  logic wr_s1_q, wr_s2_q;

  // Two-flop synchroniser for the asynchronous CPU strobe
  always_ff @(posedge CLK_n) begin
    if (RESET) begin
      wr_s1_q <= 1'b1;
      wr_s2_q <= 1'b1;
    end else begin
      wr_s1_q <= WR_n;
      wr_s2_q <= wr_s1_q;
    end
  end

  assign wr_sampled = wr_s2_q;
`else
  assign wr_sampled = WR_n;
`endif

  // Falling-edge detect and command decode
  always_comb begin
    wr_prev_d  = wr_sampled;
    wr_fall    = wr_prev_q & ~wr_sampled;
    is_pen_sel = wr_fall && (D[7:6] == 2'b00);
    is_col_wr  = wr_fall && (D[7:6] == 2'b01);
  end

  // Pending-write state machine: capture, force-commit and PIX_LOAD commit
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    col_d   = col_q;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // No bypass: even with PIX_LOAD high the new entry only gets buffered
        if (is_col_wr) begin
          tgt_d   = pen_q;
          col_d   = D[4:0];
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (is_col_wr) begin
          // A second write flushes the old entry immediately so none is lost
          commit  = 1'b1;
          tgt_d   = pen_q;
          col_d   = D[4:0];
          state_d = ST_PEND;
        end else if (PIX_LOAD) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pen select and commit of the buffered colour into ink planes or border
  always_comb begin
    pen_d    = pen_q;
    border_d = border_q;
    ink_d    = ink_q;
    if (is_pen_sel) begin
      pen_d = {D[4], D[4] ? 4'b0000 : D[3:0]};
    end
    if (commit) begin
      if (tgt_q[4]) begin
        border_d = col_q;
      end else begin
        for (int b = 0; b < 5; b++) begin
          ink_d[b][tgt_q[3:0]] = col_q[b];
        end
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK_n) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      wr_prev_q <= 1'b1;
      pen_q     <= 5'h00;
      border_q  <= 5'h00;
      tgt_q     <= 5'h00;
      col_q     <= 5'h00;
      ink_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_prev_q <= wr_prev_d;
      pen_q     <= pen_d;
      border_q  <= border_d;
      tgt_q     <= tgt_d;
      col_q     <= col_d;
      ink_q     <= ink_d;
    end
  end

  assign INKR0   = ink_q[0];
  assign INKR1   = ink_q[1];
  assign INKR2   = ink_q[2];
  assign INKR3   = ink_q[3];
  assign INKR4   = ink_q[4];
  assign BORDER  = border_q;
  assign PEN     = pen_q;
  assign PENDING = (state_q == ST_PEND);

endmodule

// File: tb/tb_ink_register_writer.sv
// Directed bench for ink_register_writer (default build, no WR_n synchroniser).
// Each table row is one CLK_n cycle: inputs applied, rising edge, outputs
// compared 1 ns later against hand-computed values.

module tb_ink_register_writer;

  logic        CLK_n;
  logic        RESET;
  logic        WR_n;
  logic [7:0]  D;
  logic        PIX_LOAD;
  logic [15:0] INKR0, INKR1, INKR2, INKR3, INKR4;
  logic [4:0]  BORDER;
  logic [4:0]  PEN;
  logic        PENDING;

  int checks = 0;
  int errors = 0;

  ink_register_writer dut (
    .CLK_n   (CLK_n),
    .RESET   (RESET),
    .WR_n    (WR_n),
    .D       (D),
    .PIX_LOAD(PIX_LOAD),
    .INKR0   (INKR0),
    .INKR1   (INKR1),
    .INKR2   (INKR2),
    .INKR3   (INKR3),
    .INKR4   (INKR4),
    .BORDER  (BORDER),
    .PEN     (PEN),
    .PENDING (PENDING)
  );

  initial CLK_n = 1'b0;
  always #5 CLK_n = ~CLK_n;

  typedef struct {
    logic        rst;
    logic        wr_n;
    logic [7:0]  d;
    logic        pix;
    logic [4:0]  pen;
    logic        pend;
    logic [4:0]  border;
    logic [79:0] ink;   // {INKR4, INKR3, INKR2, INKR1, INKR0}
  } vec_t;

  vec_t vecs[$];

  function automatic logic [79:0] mk(input logic [15:0] i4, input logic [15:0] i3,
                                     input logic [15:0] i2, input logic [15:0] i1,
                                     input logic [15:0] i0);
    return {i4, i3, i2, i1, i0};
  endfunction

  task automatic add(input logic rst, input logic wr_n, input logic [7:0] d,
                     input logic pix, input logic [4:0] pen, input logic pend,
                     input logic [4:0] border, input logic [79:0] ink);
    vec_t v;
    v.rst = rst; v.wr_n = wr_n; v.d = d; v.pix = pix;
    v.pen = pen; v.pend = pend; v.border = border; v.ink = ink;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic wr_n, input logic [7:0] d, input logic pix);
    RESET = rst; WR_n = wr_n; D = d; PIX_LOAD = pix;
    @(posedge CLK_n);
    #1;
  endtask

  logic [79:0] z, ia, ib, ic, id, ie;

  initial begin
    RESET = 1'b1; WR_n = 1'b1; D = 8'h00; PIX_LOAD = 1'b0;

    z  = '0;
    ia = mk(16'h0000, 16'h0008, 16'h0000, 16'h0008, 16'h0000);
    ib = mk(16'h0004, 16'h000C, 16'h0004, 16'h000C, 16'h0004);
    ic = mk(16'h0004, 16'h000C, 16'h0004, 16'h000C, 16'h0005);
    id = mk(16'h0004, 16'h000C, 16'h0004, 16'h000D, 16'h0004);
    ie = mk(16'h0004, 16'h000C, 16'h0005, 16'h000C, 16'h0005);

    //   rst wr  d      pix pen    pend border ink
    add(1, 1, 8'h00, 0, 5'h00, 0, 5'h00, z);   // reset
    add(0, 1, 8'h00, 0, 5'h00, 0, 5'h00, z);   // release, no spurious edge
    add(0, 0, 8'h03, 0, 5'h03, 0, 5'h00, z);   // pen 3
    add(0, 1, 8'h03, 0, 5'h03, 0, 5'h00, z);
    add(0, 0, 8'h4A, 0, 5'h03, 1, 5'h00, z);   // colour 0x0A buffered
    add(0, 1, 8'h4A, 1, 5'h03, 0, 5'h00, ia);  // commit after 1 cycle
    add(0, 0, 8'h10, 0, 5'h10, 0, 5'h00, ia);  // select border
    add(0, 1, 8'h10, 0, 5'h10, 0, 5'h00, ia);
    add(0, 0, 8'h54, 0, 5'h10, 1, 5'h00, ia);  // border colour 0x14 buffered
    add(0, 1, 8'h54, 1, 5'h10, 0, 5'h14, ia);  // commit to border only
    add(0, 0, 8'h02, 0, 5'h02, 0, 5'h14, ia);  // pen 2
    add(0, 1, 8'h02, 0, 5'h02, 0, 5'h14, ia);
    add(0, 0, 8'h5F, 1, 5'h02, 1, 5'h14, ia);  // PIX_LOAD same edge: buffer only
    add(0, 1, 8'h5F, 0, 5'h02, 1, 5'h14, ia);
    add(0, 0, 8'h07, 0, 5'h07, 1, 5'h14, ia);  // pen select while pending
    add(0, 1, 8'h07, 0, 5'h07, 1, 5'h14, ia);
    add(0, 1, 8'h07, 1, 5'h07, 0, 5'h14, ib);  // pen 2 = 0x1F, pen 7 untouched
    add(0, 0, 8'h00, 0, 5'h00, 0, 5'h14, ib);  // pen 0
    add(0, 1, 8'h00, 0, 5'h00, 0, 5'h14, ib);
    add(0, 0, 8'h41, 0, 5'h00, 1, 5'h14, ib);  // colour 0x01 buffered
    add(0, 1, 8'h41, 0, 5'h00, 1, 5'h14, ib);
    add(0, 0, 8'h42, 0, 5'h00, 1, 5'h14, ic);  // force-commit 0x01, buffer 0x02
    add(0, 1, 8'h42, 1, 5'h00, 0, 5'h14, id);  // commit 0x02
    add(0, 0, 8'h45, 0, 5'h00, 1, 5'h14, id);  // WR_n low 10 cycles
    for (int i = 0; i < 9; i++)
      add(0, 0, 8'h45, 0, 5'h00, 1, 5'h14, id);
    add(0, 1, 8'h45, 1, 5'h00, 0, 5'h14, ie);  // single commit of 0x05
    add(0, 0, 8'hC5, 0, 5'h00, 0, 5'h14, ie);  // ignored command
    add(0, 1, 8'hC5, 1, 5'h00, 0, 5'h14, ie);
    add(0, 0, 8'h85, 1, 5'h00, 0, 5'h14, ie);  // ignored command
    add(0, 1, 8'h85, 0, 5'h00, 0, 5'h14, ie);
    add(0, 0, 8'h1F, 0, 5'h10, 0, 5'h14, ie);  // D[4]=1 forces pen low bits 0
    add(0, 1, 8'h1F, 0, 5'h10, 0, 5'h14, ie);
    add(0, 0, 8'h4F, 0, 5'h10, 1, 5'h14, ie);  // pending border write
    add(1, 1, 8'h4F, 1, 5'h00, 0, 5'h00, z);   // reset discards it
    add(0, 1, 8'h4F, 1, 5'h00, 0, 5'h00, z);   // no late commit
    add(0, 1, 8'h00, 1, 5'h00, 0, 5'h00, z);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rst, vecs[i].wr_n, vecs[i].d, vecs[i].pix);
      chk($sformatf("vec%0d PEN", i), {75'd0, PEN}, {75'd0, vecs[i].pen});
      chk($sformatf("vec%0d PENDING", i), {79'd0, PENDING}, {79'd0, vecs[i].pend});
      chk($sformatf("vec%0d BORDER", i), {75'd0, BORDER}, {75'd0, vecs[i].border});
      chk($sformatf("vec%0d INKR", i), {INKR4, INKR3, INKR2, INKR1, INKR0}, vecs[i].ink);
    end

    // Hand sequence: pen 15, colour 0x01, commit delayed by three idle cycles
    cycle(0, 0, 8'h0F, 0);
    chk("seq PEN15", {75'd0, PEN}, {75'd0, 5'h0F});
    cycle(0, 1, 8'h0F, 0);
    cycle(0, 0, 8'h41, 0);
    chk("seq pend rise", {79'd0, PENDING}, {79'd0, 1'b1});
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 8'h41, 0);
      chk($sformatf("seq pend hold%0d", i), {79'd0, PENDING}, {79'd0, 1'b1});
      chk($sformatf("seq no commit%0d", i), {64'd0, INKR0}, 80'd0);
    end
    cycle(0, 1, 8'h41, 1);
    chk("seq pend fall", {79'd0, PENDING}, {79'd0, 1'b0});
    chk("seq INKR0 pen15", {64'd0, INKR0}, {64'd0, 16'h8000});
    chk("seq other planes", {16'd0, INKR4, INKR3, INKR2, INKR1}, 80'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
